// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage bus access controller:
// FSM state encoding, error codes and counter sizing.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_MISALIGN = 2'b10;

   localparam int TIMEOUT_DEFAULT = 15;
   localparam int CNT_W           = 8;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait counter for an outstanding bus access. Counts enabled cycles,
// saturates at the limit, and flags the cycle in which the count reaches it.
module mem_timeout_cnt
   import mem_access_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] count;

   // Count waiting cycles; clear wins, and the count never wraps past the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != limit)) begin
         count <= count + 1'b1;
      end
   end

   // Expired in the enabled cycle whose increment would bring the count to the limit.
   assign expired = enable && (({1'b0, count} + 9'd1) == {1'b0, limit});

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns EX/MEM load/store requests into a
// registered bus transaction, stalls the pipeline while it is outstanding,
// and reports misalignment and timeout errors.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EX_MEM_MemRd,
   input  logic        EX_MEM_MemWr,
   input  logic [31:0] EX_MEM_ALUOut,
   input  logic [31:0] EX_MEM_Rt,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        mem_stall,
   output logic [31:0] MEM_RdData,
   output logic        mem_err,
   output logic [1:0]  mem_err_code
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_t state, state_nxt;
   logic   access, aligned;
   logic   issue, misalign, complete, timeout;
   logic   expired;

   assign access  = EX_MEM_MemRd | EX_MEM_MemWr;
   assign aligned = (EX_MEM_ALUOut[1:0] == 2'b00);

   mem_timeout_cnt u_timeout_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != REQ),
      .enable  ((state == REQ) && !bus_ack),
      .limit   (LIMIT),
      .expired (expired)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, stall and the one-cycle events that steer the datapath registers.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      misalign  = 1'b0;
      complete  = 1'b0;
      timeout   = 1'b0;
      mem_stall = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               mem_stall = 1'b1;
               if (aligned) begin
                  issue     = 1'b1;
                  state_nxt = REQ;
               end else begin
                  misalign  = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         REQ: begin
            mem_stall = 1'b1;
            // An ack in the expiry cycle still completes the access normally.
            if (bus_ack) begin
               complete  = 1'b1;
               state_nxt = DONE;
            end else if (expired) begin
               timeout   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus request/data registers, load result and error reporting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         MEM_RdData   <= '0;
         mem_err      <= 1'b0;
         mem_err_code <= ERR_NONE;
      end else begin
         mem_err <= 1'b0;
         if (issue) begin
            bus_req   <= 1'b1;
            bus_we    <= EX_MEM_MemWr;   // load+store together behaves as a store
            bus_addr  <= {EX_MEM_ALUOut[31:2], 2'b00};
            bus_wdata <= EX_MEM_Rt;
         end
         if (complete) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
               MEM_RdData <= bus_rdata;
            end
         end
         if (timeout) begin
            bus_req      <= 1'b0;
            MEM_RdData   <= '0;
            mem_err      <= 1'b1;
            mem_err_code <= ERR_TIMEOUT;
         end
         if (misalign) begin
            MEM_RdData   <= '0;
            mem_err      <= 1'b1;
            mem_err_code <= ERR_MISALIGN;
         end
      end
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum number of REQ-state cycles before an access is abandoned (range 1..255).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 EX_MEM_MemRd  input  1  the instruction in the EX/MEM register is a load.
REQ-005 EX_MEM_MemWr  input  1  the instruction in the EX/MEM register is a store.
REQ-006 EX_MEM_ALUOut  input  32  byte address of the access.
REQ-007 EX_MEM_Rt  input  32  store data.
REQ-008 bus_ack  input  1  the memory/peripheral bus has completed the current access.
REQ-009 bus_rdata  input  32  read data; valid only while bus_ack=1.
REQ-010 bus_req  output  1  access request, registered.
REQ-011 bus_we  output  1  1 = write, 0 = read; registered.
REQ-012 bus_addr  output  32  word-aligned address; registered.
REQ-013 bus_wdata  output  32  write data; registered.
REQ-014 mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; combinational from state and inputs.
REQ-015 MEM_RdData  output  32  load result presented to MEM/WB; registered.
REQ-016 mem_err  output  1  one-cycle pulse when an access ends by timeout or misalignment.
REQ-017 mem_err_code  output  2  00 none, 01 timeout, 10 misaligned; holds its value until the next error or reset.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-019 IDLE: if (MemRd|MemWr) and ALUOut[1:0]=00 -> REQ, loading bus_addr, bus_wdata and bus_we (=MemWr), and setting bus_req=1.
REQ-020 IDLE: if (MemRd|MemWr) and ALUOut[1:0]!=00 -> DONE with no bus_req, MEM_RdData=0, mem_err pulse and mem_err_code=10.
REQ-021 IDLE with MemRd=MemWr=0 -> remain in IDLE; mem_stall=0.
REQ-022 MemRd=MemWr=1 simultaneously SHALL be treated as a write.
REQ-023 REQ: bus_req, bus_we, bus_addr and bus_wdata SHALL stay stable until exit.
REQ-024 REQ with bus_ack=1 -> DONE: bus_req=0; on a read, MEM_RdData<=bus_rdata.
REQ-025 REQ: the wait counter increments each cycle with bus_ack=0; on reaching TIMEOUT_CYCLES -> DONE with bus_req=0, MEM_RdData=0, mem_err pulse and mem_err_code=01.
REQ-026 A bus_ack arriving in the same cycle the counter reaches its limit SHALL take priority: normal completion, no error.
REQ-027 DONE -> IDLE unconditionally, lasting exactly one cycle; this is the single cycle in which the pipeline advances past the access.
REQ-028 mem_stall = (IDLE & (MemRd|MemWr)) | REQ; mem_stall SHALL be 0 in DONE.
REQ-029 bus_ack SHALL be ignored in IDLE and DONE.
REQ-030 Minimum latency: 2 stall cycles per access (IDLE, REQ with ack); maximum: 1+TIMEOUT_CYCLES stall cycles.
REQ-031 Back-to-back accesses SHALL each be issued exactly once, with one DONE cycle between them.
REQ-032 The wait counter SHALL clear on entry to REQ and SHALL not wrap.

Reset
REQ-033 rst=1 SHALL force IDLE, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, MEM_RdData=0, mem_err=0 and mem_err_code=00, asynchronously.
REQ-034 Reset asserted mid-REQ SHALL abandon the access immediately, with no error.
REQ-035 After reset release, the first posedge SHALL evaluate IDLE normally.

Structure
REQ-036 A shared package SHALL hold the state encoding (IDLE=2'b00, REQ=2'b01, DONE=2'b10), the error codes and the TIMEOUT_CYCLES default.
REQ-037 The wait counter SHALL be a sub-module, mem_timeout_cnt, with ports clear, enable, limit and expired.

Verification
REQ-038 Load at 0x100, bus_ack on the first REQ cycle with rdata 0x12345678 -> mem_stall high for 2 cycles, then MEM_RdData=0x12345678 in DONE and mem_err=0.
REQ-039 Store 0xCAFEBABE to 0x204, ack after 4 cycles -> bus_we=1, bus_addr=0x204 and bus_wdata held for 4 cycles; mem_stall high for 5 cycles.
REQ-040 Load from 0x102 -> no bus_req, a 1-cycle stall, mem_err pulse and mem_err_code=10.
REQ-041 Load with no ack, TIMEOUT_CYCLES=15 -> bus_req high for 15 cycles, then DONE with mem_err_code=01; repeat with ack on cycle 15 -> normal completion, no error.
REQ-042 Two consecutive loads -> exactly two bus_req assertions separated by a DONE cycle; reset asserted during the second REQ -> bus_req=0 the same cycle and no error.
